mem_access: RTL and testbench
=============================

# mem_access

- MEM-stage engine sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Turns the latched load/store (address, size, sign, store data) into a sequence of single-byte requests to the memory controller.
- Assembles and sign/zero-extends load data, and holds `stallreq_o` to the pipeline control block until the access completes.
- A done flag, cleared by the EX/MEM new-instruction pulse, keeps a held instruction from re-issuing its access.

## Interface
- No parameters. Data 32 bit, memory port 8 bit, little-endian.
- `mem_sel_i` encoding: 0 = none, 1 = byte, 2 = half, 3 = word.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `rd_i`  in  5  — destination register from EX/MEM.
- `wreg_i`  in  1  — register write enable from EX/MEM.
- `wdata_i`  in  32  — ALU result from EX/MEM.
- `addr_i`  in  32  — effective memory address.
- `reg2_i`  in  32  — store data.
- `mem_sel_i`  in  2  — access size.
- `mem_we_i`  in  1  — 1 = store, 0 = load.
- `load_sign_i`  in  1  — 1 = sign-extend load, 0 = zero-extend.
- `new_inst_i`  in  1  — one-cycle pulse from EX/MEM: a new instruction is now at the inputs.
- `mc_req_o`  out  1  — byte request to the memory controller.
- `mc_we_o`  out  1  — request is a write.
- `mc_addr_o`  out  32  — byte address.
- `mc_wdata_o`  out  8  — write byte.
- `mc_rdata_i`  in  8  — read byte, valid when `mc_ack_i` = 1.
- `mc_ack_i`  in  1  — one-cycle acknowledge of the current byte.
- `stallreq_o`  out  1  — stall request to pipeline control.
- `wb_rd_o`  out  5  — to MEM/WB.
- `wb_wreg_o`  out  1  — to MEM/WB.
- `wb_wdata_o`  out  32  — to MEM/WB.

## Operation
- `is_mem` = (`mem_sel_i` != 0). N = 1, 2 or 4 bytes for sel 1, 2 or 3.
- Registered state:
  - FSM state IDLE / ACCESS / DONE
  - byte index `idx` [1:0]
  - latched base address, N, we and sign
  - 32-bit load buffer
- IDLE:
  - `is_mem`: latch base address, N, we and sign; `idx` <= 0; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - `mc_req_o` = 1; `mc_addr_o` = base + `idx` (32-bit wrap: 0xFFFFFFFF + 1 = 0); `mc_we_o` = latched we; `mc_wdata_o` = `reg2_i`[8·idx+7 : 8·idx].
  - On `mc_ack_i`:
    - for loads, buffer byte `idx` <= `mc_rdata_i`;
    - if `idx` == N−1, go to DONE; else `idx` increments.
- DONE:
  - `mc_req_o` = 0.
  - On `new_inst_i`:
    - with `is_mem`: relatch and go directly to ACCESS, `idx` = 0;
    - otherwise go to IDLE.
  - Without `new_inst_i`: stay in DONE; the held instruction is never re-issued.
- `new_inst_i` in IDLE or ACCESS is ignored; an access in flight is never aborted except by reset.
- `stallreq_o` = `rst` & `is_mem` & (state != DONE | `new_inst_i`).
- Writeback outputs:
  - `wb_rd_o` = `rd_i`.
  - Non-load: `wb_wreg_o` = `wreg_i`, `wb_wdata_o` = `wdata_i`.
  - Load: `wb_wreg_o` = `wreg_i` & (state == DONE) & !`new_inst_i`.
  - Load data: byte → extend bit 7; half → extend bit 15; word → raw buffer. Extension is sign or zero per latched sign.
- No alignment check; misaligned half/word accesses are performed bytewise.

## Timing
- Reset (`rst` = 0 at an edge):
  - state IDLE, `idx` 0, buffer 0.
  - `mc_req_o` and `stallreq_o` are forced 0 combinationally while `rst` = 0.
  - Reset during ACCESS drops the request; a pending ack is ignored.
- With 1-cycle ack latency, each byte costs 2 cycles (req cycle + ack cycle).
- Stall length: IDLE entry gives 1 + 2N cycles (byte 3, half 5, word 9); DONE→ACCESS re-entry gives 2N.
- `stallreq_o` drops in the first DONE cycle; load data is valid on `wb_wdata_o` in that same cycle.
- Ack may arrive any number of cycles after a request.
- `mc_req_o` stays high across byte boundaries; the address changes only in the cycle after an ack.
- An ack while the FSM is not in ACCESS is ignored.

## Test plan
- Word load, addr 0x100, bytes 0x78, 0x56, 0x34, 0x12, ack 1 cycle after req → addresses 0x100..0x103 in order, `stallreq_o` high 9 cycles, `wb_wdata_o` = 0x12345678, `wb_wreg_o` = 1 in DONE.
- Byte load 0x80 with sign = 1, then the same with sign = 0 → 0xFFFFFF80, then 0x00000080. Half load 0x8001 with sign = 1 → 0xFFFF8001.
- Half store, reg2 0xAABBCCDD, addr 0x203 → writes 0xDD@0x203, 0xCC@0x204, `mc_we_o` = 1, `wb_wreg_o` = `wreg_i`.
- Load held 5 extra cycles in DONE without `new_inst_i` → no further `mc_req_o`. Then a `new_inst_i` pulse with a store at the inputs → ACCESS entered directly, `stallreq_o` high that cycle.
- `rst` = 0 after the second ack of a word load → next cycle IDLE, `mc_req_o` = 0, `stallreq_o` = 0. A stray ack afterwards changes nothing.
- Word access at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Ack delayed 3 cycles on byte 1 → address held steady until the ack.

Source files
------------

// File: rtl/mem_access_if.sv
// Byte-wide request/acknowledge link between the MEM-stage engine and the memory controller.
interface mem_access_if;
  logic        mc_req_o;
  logic        mc_we_o;
  logic [31:0] mc_addr_o;
  logic [7:0]  mc_wdata_o;
  logic [7:0]  mc_rdata_i;
  logic        mc_ack_i;

  modport master (
    output mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o,
    input  mc_rdata_i, mc_ack_i
  );

  modport slave (
    input  mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o,
    output mc_rdata_i, mc_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage engine: splits a latched load/store into little-endian byte requests,
// assembles/extends load data and stalls the pipeline until the access completes.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rd_i,
  input  logic         wreg_i,
  input  logic [31:0]  wdata_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  reg2_i,
  input  logic [1:0]   mem_sel_i,
  input  logic         mem_we_i,
  input  logic         load_sign_i,
  input  logic         new_inst_i,
  mem_access_if.master mc,
  output logic         stallreq_o,
  output logic [4:0]   wb_rd_o,
  output logic         wb_wreg_o,
  output logic [31:0]  wb_wdata_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       idx_reg;
  logic [31:0]      base_reg;
  logic [1:0]       last_reg;
  logic             we_reg;
  logic             sign_reg;
  logic [3:0][7:0]  buf_reg;

  logic             is_mem;
  logic             is_load;
  logic [1:0]       last_in;
  logic             latch_en;
  logic             byte_done;
  logic [31:0]      load_data;

  assign is_mem    = (mem_sel_i != 2'd0);
  assign is_load   = is_mem & ~mem_we_i;
  assign byte_done = (state_reg == ST_ACCESS) & mc.mc_ack_i;

  always_comb begin
    last_in = 2'd0;
    case (mem_sel_i)
      2'd2:    last_in = 2'd1;
      2'd3:    last_in = 2'd3;
      default: last_in = 2'd0;
    endcase
  end

  // A new access is captured from IDLE, or straight from DONE when the next instruction arrives.
  assign latch_en = rst & is_mem &
                    ((state_reg == ST_IDLE) | ((state_reg == ST_DONE) & new_inst_i));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_mem) begin
            idx_reg   <= 2'd0;
            state_reg <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mc.mc_ack_i) begin
            if (idx_reg == last_reg) begin
              state_reg <= ST_DONE;
            end else begin
              idx_reg <= idx_reg + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (new_inst_i) begin
            idx_reg   <= 2'd0;
            state_reg <= is_mem ? ST_ACCESS : ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      base_reg <= addr_i;
      last_reg <= last_in;
      we_reg   <= mem_we_i;
      sign_reg <= load_sign_i;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (!rst) begin
          buf_reg[gi] <= 8'h00;
        end else if (byte_done && !we_reg && (idx_reg == gi[1:0])) begin
          buf_reg[gi] <= mc.mc_rdata_i;
        end
      end
    end
  endgenerate

  assign mc.mc_req_o   = rst & (state_reg == ST_ACCESS);
  assign mc.mc_we_o    = we_reg;
  assign mc.mc_addr_o  = base_reg + {30'd0, idx_reg};
  assign mc.mc_wdata_o = reg2_i[{idx_reg, 3'b000} +: 8];

  // The DONE cycle releases the stall unless a new instruction is already waiting.
  assign stallreq_o = rst & is_mem & ((state_reg != ST_DONE) | new_inst_i);

  always_comb begin
    load_data = buf_reg;
    case (last_reg)
      2'd0:    load_data = {{24{sign_reg & buf_reg[0][7]}}, buf_reg[0]};
      2'd1:    load_data = {{16{sign_reg & buf_reg[1][7]}}, buf_reg[1], buf_reg[0]};
      default: load_data = buf_reg;
    endcase
  end

  assign wb_rd_o    = rd_i;
  assign wb_wreg_o  = is_load ? (wreg_i & (state_reg == ST_DONE) & ~new_inst_i) : wreg_i;
  assign wb_wdata_o = is_load ? load_data : wdata_i;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a cycle-stepped memory responder plus per-scenario checks.
module tb_mem_access;
  logic        clk;
  logic        rst;
  logic [4:0]  rd;
  logic        wreg;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] reg2;
  logic [1:0]  mem_sel;
  logic        mem_we;
  logic        load_sign;
  logic        new_inst;
  logic        stallreq;
  logic [4:0]  wb_rd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_if mc();

  mem_access dut (
    .clk(clk), .rst(rst), .rd_i(rd), .wreg_i(wreg), .wdata_i(wdata),
    .addr_i(addr), .reg2_i(reg2), .mem_sel_i(mem_sel), .mem_we_i(mem_we),
    .load_sign_i(load_sign), .new_inst_i(new_inst), .mc(mc),
    .stallreq_o(stallreq), .wb_rd_o(wb_rd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus-only responder: acks each byte after the requested wait and records what it saw.
  task automatic serve(input logic [31:0] rbytes, input int nbytes, input int extra1,
                       output logic [127:0] addrs, output logic [31:0] wbytes,
                       output int stall_cnt, output logic steady, output logic we_all,
                       output int first_req, output logic timeout);
    int b;
    int wait_c;
    int cyc;
    logic [31:0] prev_addr;
    b = 0; wait_c = 0; cyc = 0; prev_addr = '0;
    addrs = '0; wbytes = '0; stall_cnt = 0; steady = 1'b1; we_all = 1'b1;
    first_req = -1; timeout = 1'b0;
    while (b < nbytes && !timeout) begin
      #1;
      if (stallreq) stall_cnt++;
      if (mc.mc_req_o) begin
        if (first_req < 0) first_req = cyc;
        if (!mc.mc_we_o) we_all = 1'b0;
        if (wait_c > 0 && mc.mc_addr_o !== prev_addr) steady = 1'b0;
        prev_addr = mc.mc_addr_o;
        if (wait_c >= ((b == 1) ? 1 + extra1 : 1)) begin
          mc.mc_ack_i = 1'b1;
          mc.mc_rdata_i = rbytes[8*b +: 8];
          addrs[32*b +: 32] = mc.mc_addr_o;
          wbytes[8*b +: 8] = mc.mc_wdata_o;
          b++;
          wait_c = 0;
        end else begin
          mc.mc_ack_i = 1'b0;
          wait_c++;
        end
      end else begin
        mc.mc_ack_i = 1'b0;
      end
      @(negedge clk);
      new_inst = 1'b0;
      mc.mc_ack_i = 1'b0;
      cyc++;
      if (cyc > 200) timeout = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; new_inst = 1'b0; mc.mc_ack_i = 1'b0; mem_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_op(input logic [1:0] sel, input logic we, input logic sgn,
                        input logic [31:0] a, input logic [31:0] r2);
    mem_sel = sel; mem_we = we; load_sign = sgn; addr = a; reg2 = r2;
  endtask

  task automatic test_reset();
    logic [31:0] a0;
    rst = 1'b0; set_op(2'd3, 1'b0, 1'b0, 32'h100, 32'h0);
    rd = 5'd3; wreg = 1'b1; wdata = 32'h0; new_inst = 1'b0;
    mc.mc_ack_i = 1'b0; mc.mc_rdata_i = 8'h00;
    @(negedge clk); #1;
    n_cmp++; if (mc.mc_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mc.mc_req_o); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stallreq); end
    rst = 1'b1; #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL idle_stall: got %b want 1", stallreq); end
    n_cmp++; if (mc.mc_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", mc.mc_req_o); end
    n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("FAIL idle_load_wreg: got %b want 0", wb_wreg); end
    a0 = mc.mc_addr_o;
    $display("txn reset: req=%b stall=%b addr=%h", mc.mc_req_o, stallreq, a0);
  endtask

  task automatic test_word_load();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    apply_reset();
    set_op(2'd3, 1'b0, 1'b0, 32'h100, 32'h0); rd = 5'd5; wreg = 1'b1; wdata = 32'hDEADBEEF;
    serve(32'h12345678, 4, 0, ad, wb, sc, st, wa, fr, to);
    #1;
    $display("txn word_load: addr=%h data=%h stall=%0d", addr, wb_wdata, sc);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL word_timeout: got %b want 0", to); end
    n_cmp++; if (ad !== {32'h103, 32'h102, 32'h101, 32'h100}) begin n_bad++; $display("FAIL word_addrs: got %h want 103/102/101/100", ad); end
    n_cmp++; if (sc !== 9) begin n_bad++; $display("FAIL word_stall_len: got %0d want 9", sc); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL word_done_stall: got %b want 0", stallreq); end
    n_cmp++; if (wb_wdata !== 32'h12345678) begin n_bad++; $display("FAIL word_data: got %h want 12345678", wb_wdata); end
    n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("FAIL word_wreg: got %b want 1", wb_wreg); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_bad++; $display("FAIL word_rd: got %0d want 5", wb_rd); end
  endtask

  task automatic test_extend();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    apply_reset();
    set_op(2'd1, 1'b0, 1'b1, 32'h10, 32'h0);
    serve(32'h00000080, 1, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn byte_load_s: addr=%h data=%h stall=%0d", ad[31:0], wb_wdata, sc);
    n_cmp++; if (wb_wdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_sext: got %h want ffffff80", wb_wdata); end
    n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL byte_stall_len: got %0d want 3", sc); end
    apply_reset();
    set_op(2'd1, 1'b0, 1'b0, 32'h10, 32'h0);
    serve(32'h00000080, 1, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn byte_load_z: addr=%h data=%h stall=%0d", ad[31:0], wb_wdata, sc);
    n_cmp++; if (wb_wdata !== 32'h00000080) begin n_bad++; $display("FAIL byte_zext: got %h want 00000080", wb_wdata); end
    apply_reset();
    set_op(2'd2, 1'b0, 1'b1, 32'h20, 32'h0);
    serve(32'h00008001, 2, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn half_load_s: addr=%h data=%h stall=%0d", ad[31:0], wb_wdata, sc);
    n_cmp++; if (wb_wdata !== 32'hFFFF8001) begin n_bad++; $display("FAIL half_sext: got %h want ffff8001", wb_wdata); end
    n_cmp++; if (sc !== 5) begin n_bad++; $display("FAIL half_stall_len: got %0d want 5", sc); end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL extend_timeout: got %b want 0", to); end
  endtask

  task automatic test_half_store();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    apply_reset();
    set_op(2'd2, 1'b1, 1'b0, 32'h203, 32'hAABBCCDD); wreg = 1'b1; wdata = 32'h11223344;
    #1;
    n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("FAIL store_wreg_pass: got %b want 1", wb_wreg); end
    serve(32'h0, 2, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn half_store: addr=%h bytes=%h stall=%0d", ad[31:0], wb[15:0], sc);
    n_cmp++; if (ad[63:0] !== {32'h204, 32'h203}) begin n_bad++; $display("FAIL store_addrs: got %h want 204/203", ad[63:0]); end
    n_cmp++; if (wb[15:0] !== 16'hCCDD) begin n_bad++; $display("FAIL store_bytes: got %h want ccdd", wb[15:0]); end
    n_cmp++; if (wa !== 1'b1) begin n_bad++; $display("FAIL store_we: got %b want 1", wa); end
    n_cmp++; if (wb_wdata !== 32'h11223344) begin n_bad++; $display("FAIL store_wdata: got %h want 11223344", wb_wdata); end
    wreg = 1'b0; #1;
    n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("FAIL store_wreg_follow: got %b want 0", wb_wreg); end
  endtask

  task automatic test_hold_reissue();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    int extra_req;
    apply_reset();
    set_op(2'd1, 1'b0, 1'b0, 32'h600, 32'h0); wreg = 1'b1;
    serve(32'h0000009C, 1, 0, ad, wb, sc, st, wa, fr, to);
    extra_req = 0;
    repeat (5) begin
      #1; if (mc.mc_req_o || stallreq) extra_req++;
      @(negedge clk);
    end
    #1;
    $display("txn hold_load: addr=%h data=%h extra_req=%0d", ad[31:0], wb_wdata, extra_req);
    n_cmp++; if (extra_req !== 0) begin n_bad++; $display("FAIL hold_no_reissue: got %0d want 0", extra_req); end
    n_cmp++; if (wb_wdata !== 32'h0000009C) begin n_bad++; $display("FAIL hold_data: got %h want 0000009c", wb_wdata); end
    n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("FAIL hold_wreg: got %b want 1", wb_wreg); end
    set_op(2'd1, 1'b1, 1'b0, 32'h40, 32'h0000005A); wreg = 1'b0; new_inst = 1'b1;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL reentry_stall: got %b want 1", stallreq); end
    serve(32'h0, 1, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn reentry_store: addr=%h byte=%h first_req=%0d", ad[31:0], wb[7:0], fr);
    n_cmp++; if (fr !== 1) begin n_bad++; $display("FAIL reentry_direct: got %0d want 1", fr); end
    n_cmp++; if (ad[31:0] !== 32'h40) begin n_bad++; $display("FAIL reentry_addr: got %h want 00000040", ad[31:0]); end
    n_cmp++; if (wb[7:0] !== 8'h5A) begin n_bad++; $display("FAIL reentry_byte: got %h want 5a", wb[7:0]); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    apply_reset();
    set_op(2'd3, 1'b0, 1'b0, 32'h300, 32'h0); wreg = 1'b1;
    serve(32'hA1A2A3A4, 2, 0, ad, wb, sc, st, wa, fr, to); #1;
    n_cmp++; if (mc.mc_req_o !== 1'b1) begin n_bad++; $display("FAIL mid_req_before: got %b want 1", mc.mc_req_o); end
    rst = 1'b0; #1;
    n_cmp++; if (mc.mc_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_req_forced: got %b want 0", mc.mc_req_o); end
    @(negedge clk); #1;
    n_cmp++; if (mc.mc_req_o !== 1'b0 || stallreq !== 1'b0) begin n_bad++; $display("FAIL mid_after_reset: got req=%b stall=%b want 0/0", mc.mc_req_o, stallreq); end
    mem_sel = 2'd0; rst = 1'b1; mc.mc_ack_i = 1'b1; mc.mc_rdata_i = 8'hEE;
    @(negedge clk); mc.mc_ack_i = 1'b0; #1;
    n_cmp++; if (mc.mc_req_o !== 1'b0 || stallreq !== 1'b0) begin n_bad++; $display("FAIL stray_ack: got req=%b stall=%b want 0/0", mc.mc_req_o, stallreq); end
    set_op(2'd1, 1'b0, 1'b1, 32'h500, 32'h0);
    serve(32'h0000007F, 1, 0, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn after_reset_load: addr=%h data=%h stall=%0d", ad[31:0], wb_wdata, sc);
    n_cmp++; if (ad[31:0] !== 32'h500) begin n_bad++; $display("FAIL post_reset_addr: got %h want 00000500", ad[31:0]); end
    n_cmp++; if (wb_wdata !== 32'h0000007F) begin n_bad++; $display("FAIL post_reset_data: got %h want 0000007f", wb_wdata); end
    n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL post_reset_stall: got %0d want 3", sc); end
  endtask

  task automatic test_wrap_delay();
    logic [127:0] ad; logic [31:0] wb; int sc; logic st; logic wa; int fr; logic to;
    apply_reset();
    set_op(2'd3, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0); wreg = 1'b1;
    serve(32'h01020304, 4, 3, ad, wb, sc, st, wa, fr, to); #1;
    $display("txn wrap_load: addr=%h data=%h stall=%0d", ad[31:0], wb_wdata, sc);
    n_cmp++; if (ad !== {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}) begin n_bad++; $display("FAIL wrap_addrs: got %h want 1/0/ffffffff/fffffffe", ad); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL wrap_addr_steady: got %b want 1", st); end
    n_cmp++; if (sc !== 12) begin n_bad++; $display("FAIL wrap_stall_len: got %0d want 12", sc); end
    n_cmp++; if (wb_wdata !== 32'h01020304) begin n_bad++; $display("FAIL wrap_data: got %h want 01020304", wb_wdata); end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout: got %b want 0", to); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_extend();
    test_half_store();
    test_hold_reissue();
    test_reset_mid();
    test_wrap_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
